// File: rtl/delayed_branch_resolver.sv
// delayed_branch_resolver: tracks delayed-branch halves through S1..S3, evaluates them at S3
// and re-injects the taken branch word while flushing the wrong path.
module delayed_branch_resolver #(
    parameter int DEPTH = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        advance_in,
    input  logic [15:0] p0_delayed_B_in,
    input  logic [2:0]  p0_delayed_cond_in,
    input  logic        p0_valid_in,
    input  logic [15:0] p1_delayed_B_in,
    input  logic [2:0]  p1_delayed_cond_in,
    input  logic        p1_valid_in,
    input  logic        N,
    input  logic        V,
    input  logic        Z,
    output logic        p0_do_delayed_B,
    output logic        p1_do_delayed_B,
    output logic [15:0] p0_IR_out,
    output logic [15:0] p1_IR_out,
    output logic        flush_out,
    output logic        busy_out
);
    typedef enum logic {IDLE, REDIRECT} state_t;

    state_t             state, state_d;
    logic [DEPTH-1:0]   v0, v1, v0_d, v1_d;
    logic [15:0]        w0 [DEPTH];
    logic [15:0]        w1 [DEPTH];
    logic [2:0]         c0 [DEPTH];
    logic [2:0]         c1 [DEPTH];
    logic               do0_d, do1_d, met0, met1, take;
    logic [15:0]        ir0_d, ir1_d;

    function automatic logic cond_met(input logic [2:0] c, input logic n, input logic v, input logic z);
        logic lt;
        lt = n ^ v;
        return c == 3'd0 ? 1'b0 :
               c == 3'd1 ? 1'b1 :
               c == 3'd2 ? z :
               c == 3'd3 ? ~z :
               c == 3'd4 ? lt :
               c == 3'd5 ? (z | lt) :
               c == 3'd6 ? (~z & ~lt) : ~lt;
    endfunction

    assign met0 = v0[DEPTH-1] && cond_met(c0[DEPTH-1], N, V, Z);
    assign met1 = v1[DEPTH-1] && cond_met(c1[DEPTH-1], N, V, Z);
    assign take = (state == IDLE) && advance_in && (met0 || met1);

    always_comb begin
        state_d = state;
        v0_d    = v0;
        v1_d    = v1;
        do0_d   = p0_do_delayed_B;
        do1_d   = p1_do_delayed_B;
        ir0_d   = p0_IR_out;
        ir1_d   = p1_IR_out;
        if (advance_in) begin
            if (state == REDIRECT) begin
                state_d = IDLE;
                do0_d   = 1'b0;
                do1_d   = 1'b0;
                ir0_d   = 16'h0000;
                ir1_d   = 16'h0000;
            end else if (take) begin
                // p0 is older, so a met p0 squashes p1
                state_d = REDIRECT;
                v0_d    = '0;
                v1_d    = '0;
                do0_d   = met0;
                do1_d   = ~met0;
                ir0_d   = met0 ? w0[DEPTH-1] : 16'h0000;
                ir1_d   = met0 ? 16'h0000 : w1[DEPTH-1];
            end else begin
                v0_d = {v0[DEPTH-2:0], p0_valid_in && (p0_delayed_cond_in != 3'd0)};
                v1_d = {v1[DEPTH-2:0], p1_valid_in && (p1_delayed_cond_in != 3'd0)};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            v0              <= '0;
            v1              <= '0;
            p0_do_delayed_B <= 1'b0;
            p1_do_delayed_B <= 1'b0;
            p0_IR_out       <= 16'h0000;
            p1_IR_out       <= 16'h0000;
        end else begin
            state           <= state_d;
            v0              <= v0_d;
            v1              <= v1_d;
            p0_do_delayed_B <= do0_d;
            p1_do_delayed_B <= do1_d;
            p0_IR_out       <= ir0_d;
            p1_IR_out       <= ir1_d;
        end
    end

    // payload needs no reset; the valid bits alone decide whether an entry exists
    always_ff @(posedge clk) begin
        if (advance_in) begin
            w0[0] <= p0_delayed_B_in;
            w1[0] <= p1_delayed_B_in;
            c0[0] <= p0_delayed_cond_in;
            c1[0] <= p1_delayed_cond_in;
            for (int i = 1; i < DEPTH; i++) begin
                w0[i] <= w0[i-1];
                w1[i] <= w1[i-1];
                c0[i] <= c0[i-1];
                c1[i] <= c1[i-1];
            end
        end
    end

    assign flush_out = (state == REDIRECT);
    assign busy_out  = (|v0) || (|v1) || (state == REDIRECT);
endmodule

// File: tb/tb_delayed_branch_resolver.sv
// tb_delayed_branch_resolver: directed scenarios plus randomized traffic checked against a
// queue-of-bundles reference model.
module tb_delayed_branch_resolver;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        advance_in = 1'b0;
    logic [15:0] p0_delayed_B_in = '0, p1_delayed_B_in = '0;
    logic [2:0]  p0_delayed_cond_in = '0, p1_delayed_cond_in = '0;
    logic        p0_valid_in = 1'b0, p1_valid_in = 1'b0;
    logic        N = 1'b0, V = 1'b0, Z = 1'b0;
    logic        p0_do_delayed_B, p1_do_delayed_B, flush_out, busy_out;
    logic [15:0] p0_IR_out, p1_IR_out;

    int total = 0;
    int bad = 0;

    delayed_branch_resolver #(.DEPTH(3)) dut (
        .clk(clk), .rst(rst), .advance_in(advance_in),
        .p0_delayed_B_in(p0_delayed_B_in), .p0_delayed_cond_in(p0_delayed_cond_in), .p0_valid_in(p0_valid_in),
        .p1_delayed_B_in(p1_delayed_B_in), .p1_delayed_cond_in(p1_delayed_cond_in), .p1_valid_in(p1_valid_in),
        .N(N), .V(V), .Z(Z),
        .p0_do_delayed_B(p0_do_delayed_B), .p1_do_delayed_B(p1_do_delayed_B),
        .p0_IR_out(p0_IR_out), .p1_IR_out(p1_IR_out),
        .flush_out(flush_out), .busy_out(busy_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v0;
        logic [15:0] w0;
        logic [2:0]  c0;
        logic        v1;
        logic [15:0] w1;
        logic [2:0]  c1;
    } bundle_t;

    // model: bundles in flight (front = youngest), redirect flag and registered outputs
    bundle_t     q[$];
    logic        m_redir, m_do0, m_do1;
    logic [15:0] m_ir0, m_ir1;

    function automatic bit flag_met(input logic [2:0] c);
        bit lt;
        lt = (N != V);
        case (c)
            3'd0: return 0;
            3'd1: return 1;
            3'd2: return Z;
            3'd3: return !Z;
            3'd4: return lt;
            3'd5: return Z || lt;
            3'd6: return !Z && !lt;
            default: return !lt;
        endcase
    endfunction

    function automatic bit m_busy();
        bit b;
        b = m_redir;
        foreach (q[i]) b = b || q[i].v0 || q[i].v1;
        return b;
    endfunction

    task automatic model_reset();
        q.delete();
        m_redir = 0; m_do0 = 0; m_do1 = 0; m_ir0 = 0; m_ir1 = 0;
    endtask

    task automatic model_edge();
        bundle_t b, nb;
        bit t0, t1, took;
        if (!rst) begin
            model_reset();
        end else if (advance_in) begin
            if (m_redir) begin
                m_redir = 0; m_do0 = 0; m_do1 = 0; m_ir0 = 0; m_ir1 = 0;
            end else begin
                took = 0;
                if (q.size() == 3) begin
                    b  = q.pop_back();
                    t0 = b.v0 && flag_met(b.c0);
                    t1 = b.v1 && flag_met(b.c1);
                    if (t0 || t1) begin
                        q.delete();
                        m_redir = 1;
                        m_do0 = t0;
                        m_do1 = !t0;
                        m_ir0 = t0 ? b.w0 : 16'h0;
                        m_ir1 = t0 ? 16'h0 : b.w1;
                        took = 1;
                    end
                end
                if (!took) begin
                    nb.v0 = p0_valid_in && p0_delayed_cond_in != 0;
                    nb.w0 = p0_delayed_B_in;
                    nb.c0 = p0_delayed_cond_in;
                    nb.v1 = p1_valid_in && p1_delayed_cond_in != 0;
                    nb.w1 = p1_delayed_B_in;
                    nb.c1 = p1_delayed_cond_in;
                    q.push_front(nb);
                end
            end
        end
    endtask

    // one clock edge: inputs stay put across the edge, outputs are sampled 1ns after it
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        p0_valid_in = 0; p1_valid_in = 0;
        p0_delayed_cond_in = 0; p1_delayed_cond_in = 0;
        p0_delayed_B_in = 0; p1_delayed_B_in = 0;
    endtask

    task automatic launch_p0_al(input logic [15:0] w);
        advance_in = 1;
        p0_valid_in = 1; p0_delayed_B_in = w; p0_delayed_cond_in = 3'd1;
        step();
        clear_inputs();
        step();
        step();
        step();
    endtask

    task automatic test_reset();
        model_reset();
        #3;
        total++;
        if ({p0_do_delayed_B, p1_do_delayed_B, flush_out, busy_out} !== 4'b0 || p0_IR_out !== 16'h0 || p1_IR_out !== 16'h0) begin
            bad++;
            $display("FAIL reset_state: do=%b%b flush=%b busy=%b ir0=%h ir1=%h, want all zero",
                     p0_do_delayed_B, p1_do_delayed_B, flush_out, busy_out, p0_IR_out, p1_IR_out);
        end
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_al_branch();
        launch_p0_al(16'h2015);
        total++;
        if (p0_do_delayed_B !== 1 || p0_IR_out !== 16'h2015 || flush_out !== 1 || p1_do_delayed_B !== 0) begin
            bad++;
            $display("FAIL al_take: do0=%b ir0=%h flush=%b do1=%b, want 1 2015 1 0",
                     p0_do_delayed_B, p0_IR_out, flush_out, p1_do_delayed_B);
        end
        step();
        total++;
        if (p0_do_delayed_B !== 0 || p0_IR_out !== 16'h0 || flush_out !== 0 || busy_out !== 0) begin
            bad++;
            $display("FAIL al_exit: do0=%b ir0=%h flush=%b busy=%b, want 0 0000 0 0",
                     p0_do_delayed_B, p0_IR_out, flush_out, busy_out);
        end
    endtask

    task automatic test_not_taken();
        Z = 0;
        advance_in = 1;
        p1_valid_in = 1; p1_delayed_B_in = 16'h2040; p1_delayed_cond_in = 3'd2;
        step();
        clear_inputs();
        total++;
        if (busy_out !== 1) begin
            bad++;
            $display("FAIL nt_busy: busy=%b, want 1", busy_out);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (p0_do_delayed_B !== 0 || p1_do_delayed_B !== 0 || flush_out !== 0) begin
                bad++;
                $display("FAIL nt_no_take: cycle %0d do=%b%b flush=%b, want 0", i, p0_do_delayed_B, p1_do_delayed_B, flush_out);
            end
        end
        total++;
        if (busy_out !== 0) begin
            bad++;
            $display("FAIL nt_retire: busy=%b, want 0", busy_out);
        end
    endtask

    task automatic test_both_met();
        N = 1; V = 0;
        advance_in = 1;
        p0_valid_in = 1; p0_delayed_B_in = 16'h1111; p0_delayed_cond_in = 3'd4;
        p1_valid_in = 1; p1_delayed_B_in = 16'h2222; p1_delayed_cond_in = 3'd1;
        for (int i = 0; i < 4; i++) begin
            step();
            p0_delayed_B_in = 16'h3300 + 16'(i);
        end
        clear_inputs();
        total++;
        if (p0_do_delayed_B !== 1 || p1_do_delayed_B !== 0 || p0_IR_out !== 16'h1111 || p1_IR_out !== 16'h0) begin
            bad++;
            $display("FAIL both_met: do=%b%b ir0=%h ir1=%h, want do=10 ir0=1111 ir1=0000",
                     p0_do_delayed_B, p1_do_delayed_B, p0_IR_out, p1_IR_out);
        end
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (p0_do_delayed_B !== 0 || p1_do_delayed_B !== 0 || busy_out !== 0) begin
                bad++;
                $display("FAIL both_met_cleared: cycle %0d do=%b%b busy=%b, want 0", i, p0_do_delayed_B, p1_do_delayed_B, busy_out);
            end
        end
        N = 0;
    endtask

    task automatic test_stall_redirect();
        launch_p0_al(16'h5a5a);
        advance_in = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (p0_IR_out !== 16'h5a5a || flush_out !== 1 || p0_do_delayed_B !== 1) begin
                bad++;
                $display("FAIL stall_hold: cycle %0d ir0=%h flush=%b do0=%b, want 5a5a 1 1", i, p0_IR_out, flush_out, p0_do_delayed_B);
            end
        end
        advance_in = 1;
        step();
        total++;
        if (flush_out !== 0 || p0_do_delayed_B !== 0 || p0_IR_out !== 16'h0) begin
            bad++;
            $display("FAIL stall_exit: flush=%b do0=%b ir0=%h, want 0 0 0000", flush_out, p0_do_delayed_B, p0_IR_out);
        end
    endtask

    task automatic test_filter();
        advance_in = 1;
        p0_valid_in = 1; p0_delayed_cond_in = 3'd0; p0_delayed_B_in = 16'hbeef;
        p1_valid_in = 0; p1_delayed_cond_in = 3'd1; p1_delayed_B_in = 16'hcafe;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (busy_out !== 0 || p0_do_delayed_B !== 0 || p1_do_delayed_B !== 0) begin
                bad++;
                $display("FAIL filter: cycle %0d busy=%b do=%b%b, want 0", i, busy_out, p0_do_delayed_B, p1_do_delayed_B);
            end
        end
        clear_inputs();
        step();
        step();
        step();
    endtask

    task automatic test_reset_mid_redirect();
        launch_p0_al(16'h7777);
        total++;
        if (flush_out !== 1) begin
            bad++;
            $display("FAIL rst_mid_pre: flush=%b, want 1", flush_out);
        end
        #2;
        rst = 0;
        model_reset();
        #1;
        total++;
        if ({p0_do_delayed_B, p1_do_delayed_B, flush_out, busy_out} !== 4'b0 || p0_IR_out !== 16'h0 || p1_IR_out !== 16'h0) begin
            bad++;
            $display("FAIL rst_mid: do=%b%b flush=%b busy=%b ir0=%h ir1=%h, want all zero",
                     p0_do_delayed_B, p1_do_delayed_B, flush_out, busy_out, p0_IR_out, p1_IR_out);
        end
        @(negedge clk);
        rst = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (busy_out !== 0 || flush_out !== 0) begin
                bad++;
                $display("FAIL rst_mid_after: cycle %0d busy=%b flush=%b, want 0", i, busy_out, flush_out);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            advance_in = ($urandom_range(3, 0) != 0);
            p0_valid_in = $urandom_range(1, 0);
            p1_valid_in = $urandom_range(1, 0);
            p0_delayed_cond_in = 3'($urandom_range(7, 0));
            p1_delayed_cond_in = 3'($urandom_range(7, 0));
            p0_delayed_B_in = 16'($urandom);
            p1_delayed_B_in = 16'($urandom);
            N = $urandom_range(1, 0);
            V = $urandom_range(1, 0);
            Z = $urandom_range(1, 0);
            step();
            total++;
            if (p0_do_delayed_B !== m_do0 || p1_do_delayed_B !== m_do1 || p0_IR_out !== m_ir0 ||
                p1_IR_out !== m_ir1 || flush_out !== m_redir || busy_out !== m_busy()) begin
                bad++;
                $display("FAIL random: cycle %0d got do=%b%b ir0=%h ir1=%h flush=%b busy=%b, want do=%b%b ir0=%h ir1=%h flush=%b busy=%b",
                         i, p0_do_delayed_B, p1_do_delayed_B, p0_IR_out, p1_IR_out, flush_out, busy_out,
                         m_do0, m_do1, m_ir0, m_ir1, m_redir, m_busy());
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_al_branch();
        test_not_taken();
        test_both_met();
        test_stall_redirect();
        test_filter();
        test_reset_mid_redirect();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/delayed_branch_resolver.md
# delayed_branch_resolver

Back end of the delayed-branch protocol. Captures the delayed branch half that branch generation emits per fetch slot (p0/p1) and carries it alongside the pipeline to stage 3. There it evaluates the stored condition against N/V/Z. When the condition is met, it re-injects the stored 16-bit branch word into the IR path with `p0_do_delayed_B`/`p1_do_delayed_B` asserted and flushes the wrong-path entries.

## Interface
- `DEPTH`, 3: pipeline stages tracked (S1..S3); evaluation happens at stage `DEPTH`.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `advance_in`  in  1  pipeline advance (fetch_next); low means stall, all state holds.
- `p0_delayed_B_in`  in  16  delayed branch word, slot 0 ({head[15:8], dest[7:0]}).
- `p0_delayed_cond_in`  in  3  delayed condition, slot 0.
- `p0_valid_in`  in  1  slot 0 bundle valid (low when BGU resets S1 or IR0 invalid).
- `p1_delayed_B_in`, `p1_delayed_cond_in`, `p1_valid_in`  in  16/3/1  same, slot 1.
- `N`, `V`, `Z`  in  1 each  flags from execute, valid for the bundle at stage `DEPTH`.
- `p0_do_delayed_B`  out  1  slot 0 carries a re-injected delayed branch.
- `p1_do_delayed_B`  out  1  slot 1 carries a re-injected delayed branch.
- `p0_IR_out`, `p1_IR_out`  out  16  re-injected branch word; 16'h0000 when not active.
- `flush_out`  out  1  kill younger pipeline contents this cycle.
- `busy_out`  out  1  any tracked entry valid or redirect pending.

## Operation
- Condition codes: NV=0 never; AL=1 always; EQ=2 Z; NE=3 ~Z; LT=4 N^V; LE=5 Z|(N^V); GT=6 ~Z&~(N^V); GE=7 ~(N^V).
- Entry = {valid, word[15:0], cond[2:0]} per slot per stage. Capture into S1 on `advance_in`. Valid = slot valid_in && cond != NV. NV entries are never stored.
- On `advance_in`, entries shift S1 to S2 to S3. The S3 entry retires whether or not its branch is taken.
- Evaluation: at S3 with `advance_in`=1, compute met0/met1 from the flags. p0 is older than p1. If met0, take p0 and squash p1. Otherwise take p1 if met1.
- Take: register the word into the taken slot's IR_out and set its do_delayed_B. Clear every entry in S1..S3 and the entries being captured that cycle. Enter REDIRECT.
- FSM states: IDLE, REDIRECT.
  - IDLE: evaluate as above. A take moves to REDIRECT.
  - REDIRECT: outputs held. `flush_out`=1. Input capture suppressed. Leave to IDLE on the first cycle with `advance_in`=1; outputs deassert on that edge.
- Halt words (head 8'b001_00_111, cond AL) are treated like any AL entry; the resolver does not interpret the head.
- `busy_out` = OR of all entry valids, or state==REDIRECT.

## Timing
- Reset (asynchronous, `rst`=0): all entries invalid. State IDLE. do_delayed_B=0, IR_out=16'h0000, flush_out=0, busy_out=0.
- Latency: capture edge k into S1. With `advance_in` high every cycle, S3 is evaluated in cycle k+2 and do_delayed_B is visible from edge k+3.
- `flush_out` is combinational from the state register: high exactly during REDIRECT.
- Stall (`advance_in`=0): no capture, shift, evaluation or state change. In REDIRECT, outputs stay stable until advance.
- Evaluation and reset together: reset wins immediately; no take is emitted.
- Both slots met: only p0 is taken; p1_do_delayed_B stays 0.
- Capture in the same cycle as a take: the new bundle is discarded (wrong path).
- A take in REDIRECT cannot occur, because entries are empty and capture is suppressed.

## Test plan
- Reset mid-REDIRECT: assert `rst`=0 asynchronously -> all outputs 0 within the same cycle, state IDLE, entries cleared.
- AL branch: p0 word 16'h2015, cond AL, valid at edge 0, advance every cycle -> from edge 3, p0_do_delayed_B=1, p0_IR_out=16'h2015, flush_out=1 for one cycle; idle after edge 4.
- Conditional not taken: p1 cond EQ, word 16'h2040, Z=0 at S3 -> entry retires, no do_delayed_B, busy_out=0 after edge 3.
- Both slots met: p0 cond LT (N=1, V=0), p1 cond AL in the same bundle -> only p0_do_delayed_B=1; younger S1/S2 entries are cleared, shown by no further takes.
- Stall during REDIRECT: hold `advance_in`=0 for 4 cycles after a take -> p0_IR_out stable and flush_out=1 all 4 cycles; exit on the first advance.
- NV and invalid filtering: cond NV valid=1, and cond AL with valid=0 -> no entries captured, busy_out stays 0.
